mem_wait_port: RTL and testbench

- Data/instruction memory port on the downstream side of the multicycle CPU controller and datapath.
- Consumes the memory write-enable, the muxed address and the write data.
- Models a word-addressed RAM with a fixed, parameterised access latency behind a req/ready/ack handshake, so the controller can stall on slow memory.
- Also provides a bench/boot preload port.

---
 rtl/mem_wait_port_if.sv | 37 +++
 rtl/mem_wait_port.sv | 149 ++++++++++++++
 tb/tb_mem_wait_port.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wait_port_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_port_if
// Description : Request/ready/ack bus between the multicycle controller and
//               the memory port, plus the boot/bench preload strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wait_port_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              busy;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  // Controller / bench side
  modport master (
    output req, we, addr, wdata, load_en, load_addr, load_data,
    input  ready, busy, ack, rdata, err
  );

  // Memory side
  modport slave (
    input  req, we, addr, wdata, load_en, load_addr, load_data,
    output ready, busy, ack, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_wait_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_port
// Description : Word-addressed RAM behind a req/ready/ack handshake with a
//               fixed access latency, so the controller can stall on slow
//               memory. Includes a preload port honoured only while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int LAT    = 3
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mem_wait_port_if.slave bus
);

  localparam int                 c_CNT_W   = 4;
  localparam logic [c_CNT_W-1:0] c_LAT_M1  = c_CNT_W'(LAT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_acc_we;
  logic [ADDR_W-1:0]  w_acc_addr;
  logic [DATA_W-1:0]  w_rd_word;
  logic               w_enter_rd;
  logic               w_commit_wr;
  logic               w_load;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  // With LAT=1 the response is entered straight from IDLE, before the
  // request has been latched, so the read source must come from the bus.
  assign w_acc_we   = (r_state == c_ST_IDLE) ? bus.we   : r_we;
  assign w_acc_addr = (r_state == c_ST_IDLE) ? bus.addr : r_addr;
  assign w_rd_word  = f_in_range(w_acc_addr) ? r_mem[w_acc_addr] : '0;
  assign w_enter_rd = (w_state_nxt == c_ST_RESP) && (r_state != c_ST_RESP) && !w_acc_we;

  // Writes land as RESP is left; preload only while idle with no request.
  assign w_commit_wr = (r_state == c_ST_RESP) && r_we && f_in_range(r_addr) && !rst;
  assign w_load      = (r_state == c_ST_IDLE) && !bus.req && bus.load_en &&
                       f_in_range(bus.load_addr) && !rst;

  assign bus.rdata = r_rdata;

  // State, latency counter, latched request and read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if ((r_state == c_ST_IDLE) && bus.req) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (w_enter_rd) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  // Next state: count down LAT-1 wait cycles, then one response cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.req) begin
          if (LAT == 1) begin
            w_state_nxt = c_ST_RESP;
          end else begin
            w_state_nxt = c_ST_WAIT;
            w_cnt_nxt   = c_LAT_M1;
          end
        end
      end
      c_ST_WAIT: begin
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = c_ST_RESP;
        end
      end
      c_ST_RESP: begin
        w_state_nxt = c_ST_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decode purely from the registered state
  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b1;
    bus.ack   = 1'b0;
    bus.err   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
      end
      c_ST_RESP: begin
        bus.ack = 1'b1;
        bus.err = !f_in_range(r_addr);
      end
      default: begin
        bus.ready = 1'b0;
      end
    endcase
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_commit_wr) begin
      r_mem[r_addr] <= r_wdata;
    end else if (w_load) begin
      r_mem[bus.load_addr] <= bus.load_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wait_port
// Description : Self-checking bench for mem_wait_port. Instance 0 uses LAT=3,
//               DEPTH=200; instance 1 uses LAT=1, DEPTH=256. A cycle-count
//               model predicts every output; directed literals pin it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wait_port;

  localparam int c_LAT   [2] = '{3, 1};
  localparam int c_DEPTH [2] = '{200, 256};

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_on = 1'b0;

  logic       d_req       [2];
  logic       d_we        [2];
  logic [7:0] d_addr      [2];
  logic [7:0] d_wdata     [2];
  logic       d_load_en   [2];
  logic [7:0] d_load_addr [2];
  logic [7:0] d_load_data [2];

  logic       o_ready [2];
  logic       o_busy  [2];
  logic       o_ack   [2];
  logic       o_err   [2];
  logic [7:0] o_rdata [2];

  mem_wait_port_if #(.DATA_W(8), .ADDR_W(8)) if0 ();
  mem_wait_port_if #(.DATA_W(8), .ADDR_W(8)) if1 ();

  assign if0.req = d_req[0];       assign if1.req = d_req[1];
  assign if0.we = d_we[0];         assign if1.we = d_we[1];
  assign if0.addr = d_addr[0];     assign if1.addr = d_addr[1];
  assign if0.wdata = d_wdata[0];   assign if1.wdata = d_wdata[1];
  assign if0.load_en = d_load_en[0];     assign if1.load_en = d_load_en[1];
  assign if0.load_addr = d_load_addr[0]; assign if1.load_addr = d_load_addr[1];
  assign if0.load_data = d_load_data[0]; assign if1.load_data = d_load_data[1];

  assign o_ready[0] = if0.ready;   assign o_ready[1] = if1.ready;
  assign o_busy[0]  = if0.busy;    assign o_busy[1]  = if1.busy;
  assign o_ack[0]   = if0.ack;     assign o_ack[1]   = if1.ack;
  assign o_err[0]   = if0.err;     assign o_err[1]   = if1.err;
  assign o_rdata[0] = if0.rdata;   assign o_rdata[1] = if1.rdata;

  mem_wait_port #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .LAT(3)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  mem_wait_port #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: m_left counts the busy cycles still to go; 1 means the ack cycle
  int         m_left  [2] = '{0, 0};
  logic       m_we    [2];
  logic [7:0] m_addr  [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_rdata [2];
  logic [7:0] m_mem   [2][256];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k]  <= 0;
        m_rdata[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int         nl;
        logic       cw;
        logic [7:0] ca;
        nl = m_left[k];
        cw = m_we[k];
        ca = m_addr[k];
        if (nl == 0) begin
          if (d_req[k]) begin
            cw = d_we[k];
            ca = d_addr[k];
            m_we[k]    <= d_we[k];
            m_addr[k]  <= d_addr[k];
            m_wdata[k] <= d_wdata[k];
            nl = c_LAT[k];
          end else if (d_load_en[k] && int'(d_load_addr[k]) < c_DEPTH[k]) begin
            m_mem[k][d_load_addr[k]] <= d_load_data[k];
          end
        end else begin
          if (nl == 1 && m_we[k] && int'(m_addr[k]) < c_DEPTH[k])
            m_mem[k][m_addr[k]] <= m_wdata[k];
          nl = nl - 1;
        end
        if (nl == 1 && m_left[k] != 1 && !cw)
          m_rdata[k] <= (int'(ca) < c_DEPTH[k]) ? m_mem[k][ca] : 8'h00;
        m_left[k] <= nl;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d.ready", k), 32'(o_ready[k]), 32'(m_left[k] == 0));
        check($sformatf("u%0d.busy", k),  32'(o_busy[k]),  32'(m_left[k] != 0));
        check($sformatf("u%0d.ack", k),   32'(o_ack[k]),   32'(m_left[k] == 1));
        check($sformatf("u%0d.err", k),   32'(o_err[k]),
              32'(m_left[k] == 1 && int'(m_addr[k]) >= c_DEPTH[k]));
        check($sformatf("u%0d.rdata", k), 32'(o_rdata[k]), 32'(m_rdata[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input int k, input logic [7:0] a, input logic [7:0] d);
    d_load_en[k] = 1'b1; d_load_addr[k] = a; d_load_data[k] = d;
    step();
    d_load_en[k] = 1'b0;
  endtask

  // Issue one access from an idle cycle; returns cycles from accept to ack
  task automatic run_acc(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                         output int n, output logic [7:0] rd, output logic er);
    d_req[k] = 1'b1; d_we[k] = w; d_addr[k] = a; d_wdata[k] = d;
    step();
    d_req[k] = 1'b0;
    d_load_en[k] = 1'b0;
    n = 1;
    forever begin
      @(negedge clk);
      if (o_ack[k] === 1'b1) break;
      if (n >= 20) begin
        total++; bad++;
        $display("FAIL u%0d.ack_wait: no ack after %0d cycles, expected within 20", k, n);
        break;
      end
      n++;
    end
    rd = o_rdata[k];
    er = o_err[k];
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         t0;
    logic [7:0] rd;
    logic [7:0] exp_d;
    logic       er;

    for (int k = 0; k < 2; k++) begin
      d_req[k] = 0; d_we[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
      d_load_en[k] = 0; d_load_addr[k] = 0; d_load_data[k] = 0;
    end
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst u%0d.ready", k), 32'(o_ready[k]), 32'd1);
      check($sformatf("rst u%0d.busy", k),  32'(o_busy[k]),  32'd0);
      check($sformatf("rst u%0d.ack", k),   32'(o_ack[k]),   32'd0);
      check($sformatf("rst u%0d.err", k),   32'(o_err[k]),   32'd0);
      check($sformatf("rst u%0d.rdata", k), 32'(o_rdata[k]), 32'h00);
    end
    chk_on = 1'b1;
    step();
    rst = 1'b0;

    // Basic read with LAT=3, data held after ack
    preload(0, 8'h10, 8'hA5);
    run_acc(0, 1'b0, 8'h10, 8'h00, n, rd, er);
    check("t1 latency", 32'(n), 32'd3);
    check("t1 rdata", 32'(rd), 32'hA5);
    check("t1 err", 32'(er), 32'd0);
    @(negedge clk);
    check("t1 ready after", 32'(o_ready[0]), 32'd1);
    @(negedge clk);
    check("t1 rdata held", 32'(o_rdata[0]), 32'hA5);
    step();

    // Write then read-after-write in the first idle cycle
    t0 = cyc;
    run_acc(0, 1'b1, 8'h20, 8'h3C, n, rd, er);
    check("t2 wr err", 32'(er), 32'd0);
    run_acc(0, 1'b0, 8'h20, 8'h00, n, rd, er);
    check("t2 raw rdata", 32'(rd), 32'h3C);
    check("t2 total cycles", 32'(cyc - t0), 32'd8);

    // Out-of-range accesses (DEPTH=200)
    preload(0, 8'h70, 8'h5A);
    run_acc(0, 1'b1, 8'hF0, 8'h77, n, rd, er);
    check("t3 wr err", 32'(er), 32'd1);
    run_acc(0, 1'b0, 8'hF0, 8'h00, n, rd, er);
    check("t3 rd err", 32'(er), 32'd1);
    check("t3 rd rdata", 32'(rd), 32'h00);
    run_acc(0, 1'b0, 8'h70, 8'h00, n, rd, er);
    check("t3 alias rdata", 32'(rd), 32'h5A);
    check("t3 alias err", 32'(er), 32'd0);

    // Input changes and preload attempts while busy are ignored
    preload(0, 8'h30, 8'hC3);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h30;
    step();
    d_we[0] = 1'b1; d_addr[0] = 8'h10; d_wdata[0] = 8'hEE;
    d_load_en[0] = 1'b1; d_load_addr[0] = 8'h10; d_load_data[0] = 8'h11;
    step();
    d_req[0] = 1'b0; d_we[0] = 1'b0; d_addr[0] = 8'h40;
    step();
    d_req[0] = 1'b1; d_we[0] = 1'b1;
    @(negedge clk);
    check("t4 ack", 32'(o_ack[0]), 32'd1);
    check("t4 rdata", 32'(o_rdata[0]), 32'hC3);
    step();
    d_req[0] = 1'b0; d_we[0] = 1'b0; d_load_en[0] = 1'b0;
    step();
    run_acc(0, 1'b0, 8'h10, 8'h00, n, rd, er);
    check("t4 mem10 kept", 32'(rd), 32'hA5);

    // Reset in the middle of a write
    preload(0, 8'h05, 8'h12);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h05; d_wdata[0] = 8'h99;
    step();
    d_req[0] = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("t5 ready", 32'(o_ready[0]), 32'd1);
    check("t5 ack", 32'(o_ack[0]), 32'd0);
    check("t5 rdata", 32'(o_rdata[0]), 32'h00);
    step();
    rst = 1'b0;
    run_acc(0, 1'b0, 8'h05, 8'h00, n, rd, er);
    check("t5 mem05 kept", 32'(rd), 32'h12);

    // LAT=1: request beats simultaneous preload
    preload(1, 8'h50, 8'hAA);
    d_load_en[1] = 1'b1; d_load_addr[1] = 8'h50; d_load_data[1] = 8'hBB;
    run_acc(1, 1'b0, 8'h50, 8'h00, n, rd, er);
    check("t6 latency", 32'(n), 32'd1);
    check("t6 req wins", 32'(rd), 32'hAA);
    run_acc(1, 1'b0, 8'h50, 8'h00, n, rd, er);
    check("t6 load dropped", 32'(rd), 32'hAA);

    // LAT=1: ten back-to-back reads take 20 cycles
    for (int i = 0; i < 10; i++) preload(1, 8'(8'h60 + i), 8'(8'h30 + 7 * i));
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      exp_d = 8'(8'h30 + 7 * i);
      run_acc(1, 1'b0, 8'(8'h60 + i), 8'h00, n, rd, er);
      check($sformatf("t7 rd%0d", i), 32'(rd), 32'(exp_d));
    end
    check("t7 total cycles", 32'(cyc - t0), 32'd20);

    step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
